// File: rtl/ksa8_arbiter.sv
// ksa8_arbiter
//
// Round-robin arbiter and sequencer for one shared combinational 8-bit
// Kogge-Stone adder (KSA8). It accepts one add request at a time from NREQ
// requesters over valid/ready and registers the winner's operands onto the
// adder inputs. One cycle later it captures the adder result and returns it
// with the requester ID over a valid/ready response channel.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester request pending
//   req_ready  : one-hot grant (combinational, IDLE only)
//   req_a/b    : packed operands, requester i owns bits [8i+7:8i]
//   add_a/b    : registered operands driven into the KSA8
//   add_sum    : KSA8 sum
//   add_cout   : KSA8 carry-out
//   rsp_valid  : response available
//   rsp_ready  : consumer accepts response
//   rsp_id     : requester index of the response
//   rsp_sum    : captured sum
//   rsp_cout   : captured carry-out
//   busy       : high whenever the sequencer is not IDLE
module ksa8_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  input  logic [7:0]        add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic [7:0]     addA_q;
  logic [7:0]     addB_q;
  logic           rspValid_q;
  logic [IDW-1:0] rspId_q;
  logic [7:0]     rspSum_q;
  logic           rspCout_q;

  logic [7:0]     opA [NREQ];
  logic [7:0]     opB [NREQ];
  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW:0]   candIdx;

  // Unpack the flat operand buses so the winner can index them directly.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign opA[i] = req_a[8*i +: 8];
    assign opB[i] = req_b[8*i +: 8];
  end

  // Round-robin search starting just after the last winner. The candidate
  // index is kept one bit wider so ptr+k can be wrapped by a single subtract,
  // which also works when NREQ is not a power of two.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    candIdx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      candIdx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (candIdx >= (IDW+1)'(NREQ)) begin
        candIdx = candIdx - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[candIdx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = candIdx[IDW-1:0];
      end
    end
  end

  // Grants are only offered while idle; requests arriving later simply wait.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << winner;
    end
  end

  // Sequencer: IDLE grants and loads operands, ISSUE gives the adder one full
  // cycle to settle before capture, RESP holds the result until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      id_q       <= '0;
      addA_q     <= '0;
      addB_q     <= '0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspSum_q   <= '0;
      rspCout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            addA_q  <= opA[winner];
            addB_q  <= opB[winner];
            id_q    <= winner;
            ptr_q   <= winner;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          rspSum_q   <= add_sum;
          rspCout_q  <= add_cout;
          rspId_q    <= id_q;
          rspValid_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign add_a     = addA_q;
  assign add_b     = addB_q;
  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_sum   = rspSum_q;
  assign rsp_cout  = rspCout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ksa8_arbiter.sv
// tb_ksa8_arbiter
//
// Bench for ksa8_arbiter with NREQ=4. The KSA8 is modelled as a plain 9-bit
// add on the registered operands. Expected responses are queued at grant time
// and compared in order when a response handshake is about to happen.
module tb_ksa8_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [1:0] id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstN;
  logic [NREQ-1:0] reqValid;
  logic [NREQ-1:0] reqReady;
  logic [7:0]      opA [NREQ];
  logic [7:0]      opB [NREQ];
  logic [8*NREQ-1:0] reqA;
  logic [8*NREQ-1:0] reqB;
  logic [7:0]      addA;
  logic [7:0]      addB;
  logic [7:0]      addSum;
  logic            addCout;
  logic            rspValid;
  logic            rspReady;
  logic [IDW-1:0]  rspId;
  logic [7:0]      rspSum;
  logic            rspCout;
  logic            busy;

  int   nVectors = 0;
  int   nMiscompares = 0;
  int   cyc = 0;
  exp_t sbQ [$];
  exp_t monExp;
  vec_t table_v [8];

  ksa8_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_a    (reqA),
    .req_b    (reqB),
    .add_a    (addA),
    .add_b    (addB),
    .add_sum  (addSum),
    .add_cout (addCout),
    .rsp_valid(rspValid),
    .rsp_ready(rspReady),
    .rsp_id   (rspId),
    .rsp_sum  (rspSum),
    .rsp_cout (rspCout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign reqA = {opA[3], opA[2], opA[1], opA[0]};
  assign reqB = {opB[3], opB[2], opB[1], opB[0]};

  // Shared adder model.
  assign {addCout, addSum} = {1'b0, addA} + {1'b0, addB};

  function automatic logic [8:0] modelAdd(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  task automatic pushExpected(input logic [1:0] id, input logic [7:0] sum, input logic cout);
    exp_t e;
    e.id   = id;
    e.sum  = sum;
    e.cout = cout;
    sbQ.push_back(e);
  endtask

  // Waits for any grant to be offered, then checks it targets the given id.
  // Returns at a point where the grant takes effect on the next rising edge.
  task automatic waitGrant(input logic [1:0] id, output bit ok);
    ok = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (reqReady != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) checkOutput($sformatf("grant id%0d", id), 32'(reqReady), 32'(4'b0001 << id));
    else    reportTimeout($sformatf("grant id%0d", id));
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sbQ.size() == 0 && !rspValid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) reportTimeout("scoreboard drain");
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " add_a"},     32'(addA),     32'h0);
    checkOutput({tag, " add_b"},     32'(addB),     32'h0);
    checkOutput({tag, " rsp_valid"}, 32'(rspValid), 32'h0);
    checkOutput({tag, " rsp_sum"},   32'(rspSum),   32'h0);
    checkOutput({tag, " rsp_cout"},  32'(rspCout),  32'h0);
    checkOutput({tag, " rsp_id"},    32'(rspId),    32'h0);
    checkOutput({tag, " busy"},      32'(busy),     32'h0);
    checkOutput({tag, " req_ready"}, 32'(reqReady), 32'h0);
  endtask

  task automatic applyReset();
    rstN     = 1'b0;
    reqValid = '0;
    rspReady = 1'b1;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // One table vector: present, wait for its grant, queue the expected
  // response, withdraw, then confirm the adder operands were loaded.
  task automatic applyStimulus(input vec_t v);
    bit ok;
    opA[v.id]      = v.a;
    opB[v.id]      = v.b;
    reqValid[v.id] = 1'b1;
    waitGrant(v.id, ok);
    if (ok) pushExpected(v.id, v.sum, v.cout);
    @(posedge clk);
    #1;
    reqValid[v.id] = 1'b0;
    @(negedge clk);
    checkOutput("add_a loaded", 32'(addA), 32'(v.a));
    checkOutput("add_b loaded", 32'(addB), 32'(v.b));
  endtask

  // Response checker: compares in order just before each response handshake.
  always @(negedge clk) begin
    if (rstN && rspValid && rspReady) begin
      if (sbQ.size() == 0) begin
        reportTimeout("unexpected response (empty scoreboard)");
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("rsp_id",   32'(rspId),   32'(monExp.id));
        checkOutput("rsp_sum",  32'(rspSum),  32'(monExp.sum));
        checkOutput("rsp_cout", 32'(rspCout), 32'(monExp.cout));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         ok;
    int         g1;
    int         g2;
    logic [1:0] id;
    logic [8:0] r;
    vec_t       v;

    table_v[0] = '{id: 2'd0, a: 8'hA0, b: 8'hA0, sum: 8'h40, cout: 1'b1};
    table_v[1] = '{id: 2'd0, a: 8'h58, b: 8'hF4, sum: 8'h4C, cout: 1'b1};
    table_v[2] = '{id: 2'd0, a: 8'h3D, b: 8'h0F, sum: 8'h4C, cout: 1'b0};
    table_v[3] = '{id: 2'd1, a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
    table_v[4] = '{id: 2'd2, a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
    table_v[5] = '{id: 2'd3, a: 8'h80, b: 8'h7F, sum: 8'hFF, cout: 1'b0};
    table_v[6] = '{id: 2'd1, a: 8'hC3, b: 8'h3C, sum: 8'hFF, cout: 1'b0};
    table_v[7] = '{id: 2'd2, a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};

    for (int i = 0; i < NREQ; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    reqValid = '0;
    rspReady = 1'b1;
    applyReset();

    // Single request latency: grant at N, response valid two edges later.
    $display("[TB] single request latency");
    opA[0] = 8'hA0;
    opB[0] = 8'hA0;
    reqValid = 4'b0001;
    waitGrant(2'd0, ok);
    if (ok) pushExpected(2'd0, 8'h40, 1'b1);
    @(posedge clk);
    #1;
    reqValid = '0;
    @(negedge clk);
    checkOutput("busy in ISSUE", 32'(busy), 32'h1);
    checkOutput("req_ready in ISSUE", 32'(reqReady), 32'h0);
    checkOutput("rsp_valid in ISSUE", 32'(rspValid), 32'h0);
    @(negedge clk);
    checkOutput("rsp_valid in RESP", 32'(rspValid), 32'h1);
    @(negedge clk);
    checkOutput("rsp_valid after handshake", 32'(rspValid), 32'h0);
    checkOutput("busy after handshake", 32'(busy), 32'h0);
    waitDrain();

    // Back-to-back from one requester with rsp_ready held high.
    $display("[TB] back-to-back spacing");
    opA[0] = 8'h58;
    opB[0] = 8'hF4;
    reqValid = 4'b0001;
    waitGrant(2'd0, ok);
    g1 = cyc;
    if (ok) pushExpected(2'd0, 8'h4C, 1'b1);
    @(posedge clk);
    #1;
    opA[0] = 8'h3D;
    opB[0] = 8'h0F;
    waitGrant(2'd0, ok);
    g2 = cyc;
    if (ok) pushExpected(2'd0, 8'h4C, 1'b0);
    checkOutput("grant spacing", 32'(g2 - g1), 32'd3);
    @(posedge clk);
    #1;
    reqValid = '0;
    waitDrain();

    // All requesters valid from reset: strict rotation 0,1,2,3,0.
    $display("[TB] round-robin rotation");
    applyReset();
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = 8'(16 * i);
      opB[i] = 8'h01;
    end
    reqValid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      id = 2'(k % NREQ);
      waitGrant(id, ok);
      r = modelAdd(opA[id], opB[id]);
      if (ok) pushExpected(id, r[7:0], r[8]);
      @(posedge clk);
      #1;
      if (k == 4) reqValid = '0;
    end
    waitDrain();

    // Backpressure: result held, no grants, waiting requester not dropped.
    $display("[TB] backpressure");
    rspReady = 1'b0;
    opA[2] = 8'h7F;
    opB[2] = 8'h81;
    reqValid = 4'b0100;
    waitGrant(2'd2, ok);
    if (ok) pushExpected(2'd2, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    opA[1] = 8'h12;
    opB[1] = 8'h34;
    reqValid = 4'b0010;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rspValid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportTimeout("rsp_valid under backpressure");
    for (int k = 0; k < 5; k++) begin
      checkOutput("held rsp_valid", 32'(rspValid), 32'h1);
      checkOutput("held rsp_sum",   32'(rspSum),   32'h00);
      checkOutput("held rsp_cout",  32'(rspCout),  32'h1);
      checkOutput("held rsp_id",    32'(rspId),    32'h2);
      checkOutput("held req_ready", 32'(reqReady), 32'h0);
      checkOutput("held busy",      32'(busy),     32'h1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rspReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle after release busy", 32'(busy), 32'h0);
    checkOutput("idle after release rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("waiting requester granted", 32'(reqReady), 32'b0010);
    if (reqReady == 4'b0010) pushExpected(2'd1, 8'h46, 1'b0);
    @(posedge clk);
    #1;
    reqValid = '0;
    waitDrain();

    // Wrap: requester 3 served, then 0 beats 3.
    $display("[TB] wrap and fairness");
    opA[3] = 8'h22;
    opB[3] = 8'h11;
    reqValid = 4'b1000;
    waitGrant(2'd3, ok);
    if (ok) pushExpected(2'd3, 8'h33, 1'b0);
    @(posedge clk);
    #1;
    opA[0] = 8'hFF;
    opB[0] = 8'h01;
    reqValid = 4'b1001;
    waitGrant(2'd0, ok);
    if (ok) pushExpected(2'd0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    reqValid = 4'b1000;
    waitGrant(2'd3, ok);
    r = modelAdd(opA[3], opB[3]);
    if (ok) pushExpected(2'd3, r[7:0], r[8]);
    @(posedge clk);
    #1;
    reqValid = '0;
    waitDrain();

    // Table vectors, then a few random ones checked against the model.
    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) applyStimulus(table_v[i]);
    for (int i = 0; i < 6; i++) begin
      v.id  = 2'($urandom_range(0, NREQ - 1));
      v.a   = 8'($urandom_range(0, 255));
      v.b   = 8'($urandom_range(0, 255));
      r     = modelAdd(v.a, v.b);
      v.sum = r[7:0];
      v.cout = r[8];
      applyStimulus(v);
    end
    waitDrain();

    // Reset in ISSUE discards the transaction; priority restarts at 0.
    $display("[TB] reset mid-operation");
    opA[1] = 8'h55;
    opB[1] = 8'h66;
    reqValid = 4'b0010;
    waitGrant(2'd1, ok);
    @(posedge clk);
    #1;
    reqValid = '0;
    #1;
    rstN = 1'b0;
    #1;
    checkAllZero("mid reset");
    @(negedge clk);
    rstN = 1'b1;
    opA[0] = 8'h01;
    opB[0] = 8'h02;
    opA[2] = 8'h03;
    opB[2] = 8'h04;
    reqValid = 4'b0101;
    waitGrant(2'd0, ok);
    if (ok) pushExpected(2'd0, 8'h03, 1'b0);
    @(posedge clk);
    #1;
    reqValid = 4'b0100;
    waitGrant(2'd2, ok);
    if (ok) pushExpected(2'd2, 8'h07, 1'b0);
    @(posedge clk);
    #1;
    reqValid = '0;
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
